// File: rtl/bus_breakout_arbiter.sv
// bus_breakout_arbiter: round-robin share of one combinational bus_breakout
// datapath between two requesters. Operands are registered toward the
// datapath, and the result is returned with the owner ID on a valid/ready
// response channel.
module bus_breakout_arbiter #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned B_W   = 4,
  parameter int unsigned Q_W   = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [A_W-1:0]   req0_a,
  input  logic [B_W-1:0]   req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [A_W-1:0]   req1_a,
  input  logic [B_W-1:0]   req1_b,
  output logic             req1_ready,
  output logic [A_W-1:0]   dp_a,
  output logic [B_W-1:0]   dp_b,
  input  logic [Q_W-1:0]   dp_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Q_W-1:0]   rsp_q,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] done_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   last_id;
  logic   sel;

  // Grant select: a lone requester wins; on a tie the one not served last wins
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_id;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  // Ready is offered only in IDLE and only to the selected requester
  always_comb begin
    req0_ready = (state == IDLE) && req0_valid && !sel;
    req1_ready = (state == IDLE) && req1_valid &&  sel;
  end

  assign busy = (state != IDLE);

  // Sequencer: accept, settle one cycle, capture result, hold response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dp_a       <= '0;
      dp_b       <= '0;
      rsp_q      <= '0;
      rsp_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      last_id    <= 1'b1;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            dp_a    <= sel ? req1_a : req0_a;
            dp_b    <= sel ? req1_b : req0_b;
            rsp_id  <= sel;
            last_id <= sel;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          rsp_q     <= dp_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            done_count <= done_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_breakout_arbiter.sv
// Directed bench for bus_breakout_arbiter. A second instance with a 2-bit
// counter shares all inputs so the counter wrap is observed alongside.
module tb_bus_breakout_arbiter;

  localparam int unsigned A_W = 4;
  localparam int unsigned B_W = 4;
  localparam int unsigned Q_W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [A_W-1:0] req0_a, req1_a;
  logic [B_W-1:0] req0_b, req1_b;
  logic           req0_ready, req1_ready;
  logic [A_W-1:0] dp_a;
  logic [B_W-1:0] dp_b;
  logic [Q_W-1:0] dp_q;
  logic           rsp_valid, rsp_ready;
  logic [Q_W-1:0] rsp_q;
  logic           rsp_id, busy;
  logic [7:0]     done_count;

  logic           req0_ready2, req1_ready2;
  logic [A_W-1:0] dp_a2;
  logic [B_W-1:0] dp_b2;
  logic [Q_W-1:0] dp_q2;
  logic           rsp_valid2, rsp_id2, busy2;
  logic [Q_W-1:0] rsp_q2;
  logic [1:0]     done_count2;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  // Datapath stubs: zero-extended sum
  assign dp_q  = Q_W'(dp_a)  + Q_W'(dp_b);
  assign dp_q2 = Q_W'(dp_a2) + Q_W'(dp_b2);

  always #5 clk = ~clk;

  bus_breakout_arbiter #(.A_W(A_W), .B_W(B_W), .Q_W(Q_W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .dp_a(dp_a), .dp_b(dp_b), .dp_q(dp_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_id(rsp_id),
    .busy(busy), .done_count(done_count)
  );

  bus_breakout_arbiter #(.A_W(A_W), .B_W(B_W), .Q_W(Q_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready2),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready2),
    .dp_a(dp_a2), .dp_b(dp_b2), .dp_q(dp_q2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_q(rsp_q2), .rsp_id(rsp_id2),
    .busy(busy2), .done_count(done_count2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request in IDLE, check it is granted, drop valid after the accept edge
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    chk("grant_ready", id ? {31'd0, req1_ready} : {31'd0, req0_ready}, 1);
    step();
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, then check payload
  task automatic expect_rsp(input string tag, input logic [5:0] q, input logic id);
    int n = 0;
    while (!rsp_valid && n < 12) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 1);
    chk({tag, "_q"},     {26'd0, rsp_q},     {26'd0, q});
    chk({tag, "_id"},    {31'd0, rsp_id},    {31'd0, id});
  endtask

  // Take the response on the next edge (rsp_ready must be high) and check counters
  task automatic consume(input string tag);
    step();
    exp_cnt++;
    chk({tag, "_cnt"},  {24'd0, done_count},  32'(exp_cnt % 256));
    chk({tag, "_cnt2"}, {30'd0, done_count2}, 32'(exp_cnt % 4));
    chk({tag, "_idle"}, {31'd0, rsp_valid},   0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    step();
    step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_busy",      {31'd0, busy},      0);
    chk("rst_count",     {24'd0, done_count}, 0);
    chk("rst_dp_a",      {28'd0, dp_a},      0);
    rst = 1'b0;
    step();

    // Single transaction with latency check: 3 + 9 = 12, id 0
    issue(1'b0, 4'd3, 4'd9);
    chk("single_busy", {31'd0, busy}, 1);
    chk("single_dp_a", {28'd0, dp_a}, 3);
    chk("single_dp_b", {28'd0, dp_b}, 9);
    chk("single_lat1", {31'd0, rsp_valid}, 0);
    step();
    chk("single_lat2", {31'd0, rsp_valid}, 0);
    step();
    chk("single_lat3", {31'd0, rsp_valid}, 1);
    expect_rsp("single", 6'd12, 1'b0);
    consume("single");

    // Backpressure: hold 5 cycles while req1 asks; nothing may move
    rsp_ready = 1'b0;
    issue(1'b0, 4'd5, 4'd6);
    req1_valid = 1'b1; req1_a = 4'd1; req1_b = 4'd1;
    expect_rsp("bp", 6'd11, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_q",   {26'd0, rsp_q},      11);
      chk("bp_hold_id",  {31'd0, rsp_id},     0);
      chk("bp_ready1",   {31'd0, req1_ready}, 0);
      chk("bp_count",    {24'd0, done_count}, 1);
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    consume("bp");

    // Reset while a response is pending
    rsp_ready = 1'b0;
    issue(1'b1, 4'd2, 4'd4);
    expect_rsp("pre_rst", 6'd6, 1'b1);
    step();
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, rsp_valid},  0);
    chk("mid_rst_busy",  {31'd0, busy},       0);
    chk("mid_rst_count", {24'd0, done_count}, 0);
    chk("mid_rst_cnt2",  {30'd0, done_count2}, 0);
    chk("mid_rst_dp_a",  {28'd0, dp_a},       0);
    chk("mid_rst_dp_b",  {28'd0, dp_b},       0);
    chk("mid_rst_q",     {26'd0, rsp_q},      0);
    rst = 1'b0;
    exp_cnt = 0;
    rsp_ready = 1'b1;
    step();

    // Tie: both held valid, req0 first after reset, then alternating
    req0_valid = 1'b1; req0_a = 4'd1;  req0_b = 4'd1;
    req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
    #1;
    chk("tie_ready0", {31'd0, req0_ready}, 1);
    chk("tie_ready1", {31'd0, req1_ready}, 0);
    expect_rsp("tie1", 6'd2, 1'b0);
    consume("tie1");
    expect_rsp("tie2", 6'd30, 1'b1);
    consume("tie2");
    expect_rsp("tie3", 6'd2, 1'b0);
    consume("tie3");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Withdraw: req1 pulses for one cycle while busy and must never be served
    issue(1'b0, 4'd7, 4'd8);
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd3;
    #1;
    chk("wd_ready1", {31'd0, req1_ready}, 0);
    step();
    req1_valid = 1'b0;
    expect_rsp("wd", 6'd15, 1'b0);
    consume("wd");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_no_rsp",  {31'd0, rsp_valid}, 0);
      chk("wd_no_busy", {31'd0, busy},      0);
    end
    issue(1'b0, 4'd15, 4'd15);
    expect_rsp("last", 6'd30, 1'b0);
    consume("last");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
